// File: rtl/pec_cluster_ctrl_pkg.sv
// Shared types and defaults for the PEC cluster controller: FSM states,
// default geometry and the psum address wrap-increment helper.
package pec_cluster_ctrl_pkg;

    localparam int CH_DEF       = 32;
    localparam int DW_DEF       = 8;
    localparam int LEN_PSUM_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CFGWEI  = 2'd1,
        WAITACT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Next psum row address: wraps to 0 after the last configured row.
    function automatic int unsigned addr_wrap_inc(input int unsigned addr,
                                                  input int unsigned len);
        return (addr + 32'd1 >= len) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/pec_psum_addr.sv
// Psum SRAM row address counter: advances on en, wraps at len-1,
// synchronous clear has priority over advance.
module pec_psum_addr
    import pec_cluster_ctrl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [AW:0]   len,
    output logic [AW-1:0] addr
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en) begin
            addr <= AW'(addr_wrap_inc(32'(addr), 32'(len)));
        end
    end

endmodule

// File: rtl/pec_cluster_ctrl.sv
// PEC cluster controller: activation handshake with zero-skip, MAC
// start/finish tracking, and psum SRAM row addressing with overflow flag.
module pec_cluster_ctrl
    import pec_cluster_ctrl_pkg::*;
#(
    parameter int CH       = CH_DEF,
    parameter int DW       = DW_DEF,
    parameter int KH       = 3,
    parameter int KW       = 3,
    parameter int LEN_PSUM = LEN_PSUM_DEF,
    parameter int AW       = $clog2(LEN_PSUM),
    parameter int LAST     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sta_row,
    input  logic             fnh_row,
    input  logic             fnh_blk,
    input  logic [AW:0]      cfg_len,
    input  logic             wei_rdy,
    input  logic             lst_rdy,
    output logic             lst_get,
    input  logic [CH-1:0]    flg_act_i,
    input  logic [DW*CH-1:0] act_i,
    output logic             nxt_rdy,
    input  logic             nxt_get,
    output logic [CH-1:0]    flg_act_o,
    output logic [DW*CH-1:0] act_o,
    output logic             mac_sta,
    input  logic [KH*KW-1:0] mac_fnh,
    output logic             pls_acc,
    output logic             ram_en_rd,
    output logic             ram_en_wr,
    output logic [AW-1:0]    ram_addr_rd,
    output logic [AW-1:0]    ram_addr_wr,
    output logic             err_ovf
);

    localparam int NM = KH * KW;
    localparam logic [NM-1:0] MASK_FULL = '1;

    state_t        state, state_nxt;
    logic          abort;
    logic          act_take;
    logic          flg_nz;
    logic [NM-1:0] done;
    logic          done_full;
    logic [AW:0]   len_q;
    logic [AW:0]   rd_ext, wr_ext, lag;
    logic          ovf_hit;

    assign abort     = fnh_blk && (state != IDLE);
    assign flg_nz    = |flg_act_i;
    assign done_full = (done == MASK_FULL);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        act_take  = 1'b0;
        nxt_rdy   = 1'b0;
        case (state)
            IDLE:    state_nxt = CFGWEI;
            CFGWEI:  if (wei_rdy) state_nxt = WAITACT;
            WAITACT: begin
                if (lst_get) begin
                    act_take  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                nxt_rdy = 1'b1;
                if ((LAST != 0) || nxt_get) state_nxt = WAITACT;
            end
            default: state_nxt = IDLE;
        endcase
        // Block abort overrides any handshake in flight.
        if (abort) begin
            state_nxt = IDLE;
            act_take  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // lst_get is issued one cycle into WAITACT; the act is captured on the
    // edge that ends the lst_get cycle, and mac_sta follows on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lst_get   <= 1'b0;
            mac_sta   <= 1'b0;
            pls_acc   <= 1'b0;
            done      <= MASK_FULL;
            flg_act_o <= '0;
            act_o     <= '0;
        end else if (abort) begin
            lst_get <= 1'b0;
            mac_sta <= 1'b0;
            pls_acc <= 1'b0;
            done    <= MASK_FULL;
        end else begin
            lst_get <= (state == WAITACT) && !lst_get && lst_rdy && done_full;
            mac_sta <= act_take && flg_nz;
            pls_acc <= (act_take && !flg_nz)
                    || (!done_full && ((done | mac_fnh) == MASK_FULL));
            if (act_take) begin
                flg_act_o <= flg_act_i;
                act_o     <= act_i;
                done      <= flg_nz ? '0 : MASK_FULL;
            end else begin
                done <= done | mac_fnh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              len_q <= (AW+1)'(LEN_PSUM);
        else if (state == IDLE)  len_q <= cfg_len;
    end

    assign ram_en_rd = sta_row;
    assign ram_en_wr = fnh_row;

    pec_psum_addr #(.AW(AW)) u_addr_rd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .en    (sta_row),
        .len   (len_q),
        .addr  (ram_addr_rd)
    );

    pec_psum_addr #(.AW(AW)) u_addr_wr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .en    (fnh_row),
        .len   (len_q),
        .addr  (ram_addr_wr)
    );

    // Rows in flight = read address minus write address, modulo len.
    assign rd_ext  = {1'b0, ram_addr_rd};
    assign wr_ext  = {1'b0, ram_addr_wr};
    assign lag     = (rd_ext >= wr_ext) ? (rd_ext - wr_ext) : (rd_ext + len_q - wr_ext);
    assign ovf_hit = (sta_row && (lag > (AW+1)'(1)))
                  || (fnh_row && (ram_addr_wr == ram_addr_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_ovf <= 1'b0;
        else if (ovf_hit) err_ovf <= 1'b1;
    end

endmodule

// File: tb/tb_pec_cluster_ctrl.sv
// Self-checking bench for pec_cluster_ctrl: scoreboard queues hold expected
// activations and row addresses, popped when the DUT presents them.
module tb_pec_cluster_ctrl;

    localparam int CH       = 32;
    localparam int DW       = 8;
    localparam int KH       = 3;
    localparam int KW       = 3;
    localparam int LEN_PSUM = 16;
    localparam int AW       = 4;
    localparam int NM       = KH * KW;

    logic             clk;
    logic             rst_n;
    logic             sta_row, fnh_row, fnh_blk;
    logic [AW:0]      cfg_len;
    logic             wei_rdy, lst_rdy, lst_get;
    logic [CH-1:0]    flg_act_i, flg_act_o;
    logic [DW*CH-1:0] act_i, act_o;
    logic             nxt_rdy, nxt_get;
    logic             mac_sta, pls_acc;
    logic [NM-1:0]    mac_fnh;
    logic             ram_en_rd, ram_en_wr;
    logic [AW-1:0]    ram_addr_rd, ram_addr_wr;
    logic             err_ovf;

    typedef struct {
        logic [CH-1:0]    flg;
        logic [DW*CH-1:0] act;
    } act_t;

    act_t act_q[$];
    int   rd_q[$];
    int   wr_q[$];
    int   n_cmp, n_err, cyc;
    int   rd_m, wr_m, len_m;
    int   pls_cnt;
    logic found;

    pec_cluster_ctrl #(
        .CH(CH), .DW(DW), .KH(KH), .KW(KW), .LEN_PSUM(LEN_PSUM), .AW(AW), .LAST(0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sta_row     (sta_row),
        .fnh_row     (fnh_row),
        .fnh_blk     (fnh_blk),
        .cfg_len     (cfg_len),
        .wei_rdy     (wei_rdy),
        .lst_rdy     (lst_rdy),
        .lst_get     (lst_get),
        .flg_act_i   (flg_act_i),
        .act_i       (act_i),
        .nxt_rdy     (nxt_rdy),
        .nxt_get     (nxt_get),
        .flg_act_o   (flg_act_o),
        .act_o       (act_o),
        .mac_sta     (mac_sta),
        .mac_fnh     (mac_fnh),
        .pls_acc     (pls_acc),
        .ram_en_rd   (ram_en_rd),
        .ram_en_wr   (ram_en_wr),
        .ram_addr_rd (ram_addr_rd),
        .ram_addr_wr (ram_addr_wr),
        .err_ovf     (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [DW*CH-1:0] rand_act();
        logic [DW*CH-1:0] a;
        for (int i = 0; i < DW*CH/32; i++) a[i*32 +: 32] = $urandom;
        return a;
    endfunction

    task automatic push_act(input logic [CH-1:0] f, input logic [DW*CH-1:0] a);
        act_t e;
        e.flg     = f;
        e.act     = a;
        flg_act_i = f;
        act_i     = a;
        act_q.push_back(e);
    endtask

    task automatic pop_act();
        act_t e;
        if (act_q.size() == 0) begin
            check("act_q_empty", 1'b1, 1'b0);
        end else begin
            e = act_q.pop_front();
            check("flg_act_o", flg_act_o, e.flg);
            check("act_o", act_o, e.act);
        end
    endtask

    // One cycle of row events; expected addresses queued at drive time.
    task automatic row(input logic s, input logic f);
        sta_row = s;
        fnh_row = f;
        if (s) begin rd_q.push_back(rd_m); rd_m = (rd_m + 1) % len_m; end
        if (f) begin wr_q.push_back(wr_m); wr_m = (wr_m + 1) % len_m; end
        #1;
        check("ram_en_rd", ram_en_rd, s);
        check("ram_en_wr", ram_en_wr, f);
        if (s) check("ram_addr_rd", ram_addr_rd, rd_q.pop_front());
        if (f) check("ram_addr_wr", ram_addr_wr, wr_q.pop_front());
        tick();
        sta_row = 1'b0;
        fnh_row = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; pls_cnt = 0;
        rst_n = 1'b0; sta_row = 1'b0; fnh_row = 1'b0; fnh_blk = 1'b0;
        cfg_len = 5'd5; wei_rdy = 1'b0; lst_rdy = 1'b0; nxt_get = 1'b0;
        flg_act_i = '0; act_i = '0; mac_fnh = '0;

        repeat (3) @(negedge clk);
        check("rst_nxt_rdy", nxt_rdy, 1'b0);
        check("rst_lst_get", lst_get, 1'b0);
        check("rst_mac_sta", mac_sta, 1'b0);
        check("rst_pls_acc", pls_acc, 1'b0);
        check("rst_err_ovf", err_ovf, 1'b0);
        check("rst_act_o", act_o, '0);
        check("rst_addr_rd", ram_addr_rd, '0);
        check("rst_addr_wr", ram_addr_wr, '0);

        // Cycle 0: reset released, IDLE.
        rst_n = 1'b1; cyc = 0; len_m = 5; rd_m = 0; wr_m = 0;
        lst_rdy = 1'b1;
        push_act(32'h0000_0101, rand_act());

        for (int c = 1; c <= 6; c++) begin
            tick();
            check("a_lst_get", lst_get, c == 5);
            check("a_mac_sta", mac_sta, c == 6);
            check("a_nxt_rdy", nxt_rdy, c == 6);
            check("a_pls_acc", pls_acc, 1'b0);
            if (c == 3) wei_rdy = 1'b1;
        end
        pop_act();
        push_act('0, rand_act());

        // Staggered MAC finishes, then a zero-flag act.
        for (int c = 7; c <= 18; c++) begin
            if (c > 6) tick();
            check("b_pls_acc", pls_acc, (c == 16) || (c == 18));
            check("b_lst_get", lst_get, c == 17);
            check("b_mac_sta", mac_sta, 1'b0);
            check("b_nxt_rdy", nxt_rdy, (c <= 8) || (c == 18));
            if (pls_acc && c <= 17) pls_cnt++;
            mac_fnh = (c >= 7 && c <= 15) ? NM'(1) << (c - 7) : '0;
            nxt_get = (c == 8);
        end
        check("b_pls_single", pls_cnt, 1);
        pop_act();
        push_act(32'h8000_0000, rand_act());
        nxt_get = 1'b1;

        // Next act accepted with no mac_fnh after zero-skip.
        for (int c = 19; c <= 21; c++) begin
            tick();
            check("c_lst_get", lst_get, c == 20);
            check("c_mac_sta", mac_sta, c == 21);
            check("c_nxt_rdy", nxt_rdy, c == 21);
            check("c_pls_acc", pls_acc, 1'b0);
            if (c == 19) nxt_get = 1'b0;
        end
        pop_act();

        // Row addressing with len 5; cfg_len change outside IDLE is ignored.
        cfg_len = 5'd7;
        for (int i = 0; i < 7; i++) begin
            row(1'b1, 1'b0);
            row(1'b0, 1'b1);
        end
        check("d_err_ovf_pairs", err_ovf, 1'b0);
        row(1'b1, 1'b0);
        row(1'b1, 1'b1);
        row(1'b0, 1'b1);
        check("d_err_ovf_simul", err_ovf, 1'b0);
        check("d_still_hold", nxt_rdy, 1'b1);

        // Abort in HOLD with simultaneous nxt_get.
        fnh_blk = 1'b1; nxt_get = 1'b1; wei_rdy = 1'b0;
        tick();
        fnh_blk = 1'b0; nxt_get = 1'b0;
        check("e_nxt_rdy", nxt_rdy, 1'b0);
        check("e_addr_rd", ram_addr_rd, '0);
        check("e_addr_wr", ram_addr_wr, '0);
        check("e_mac_sta", mac_sta, 1'b0);
        rd_m = 0; wr_m = 0; len_m = 7;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("e_no_nxt_rdy", nxt_rdy, 1'b0);
            check("e_no_lst_get", lst_get, 1'b0);
        end
        row(1'b1, 1'b0);
        row(1'b0, 1'b1);
        check("e_err_ovf", err_ovf, 1'b0);

        // Reset while an act transfer is in flight.
        push_act(32'h00ff_0000, rand_act());
        wei_rdy = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (lst_get) found = 1'b1;
        end
        check("f_lst_get_seen", found, 1'b1);
        rst_n = 1'b0;
        #1;
        act_q.delete();
        check("f_lst_get", lst_get, 1'b0);
        check("f_act_o", act_o, '0);
        check("f_flg_act_o", flg_act_o, '0);
        check("f_nxt_rdy", nxt_rdy, 1'b0);
        wei_rdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1; rd_m = 0; wr_m = 0; len_m = 7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f_post_lst_get", lst_get, 1'b0);
            check("f_post_nxt_rdy", nxt_rdy, 1'b0);
            check("f_post_act_o", act_o, '0);
        end

        // Write-back with nothing read: overflow.
        check("g_err_before", err_ovf, 1'b0);
        row(1'b0, 1'b1);
        row(1'b0, 1'b1);
        check("g_err_after", err_ovf, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pec_cluster_ctrl.md
PEC_CLUSTER_CTRL -- requirements
Module: pec_cluster_ctrl

Interface
REQ-001 SHALL have parameters: CH=32 (channel depth); DW=8 (activation bits); KH=3, KW=3 (kernel rows/cols, 1..7); LEN_PSUM=16 (psum rows per block); AW=$clog2(LEN_PSUM); LAST=0 (1 = last in chain, nxt_get ignored).
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sta_row  in  1  row-start pulse
- fnh_row  in  1  row-finish pulse
- fnh_blk  in  1  block-finish pulse, abort
- cfg_len  in  AW+1  psum rows in block, 1..LEN_PSUM
- wei_rdy  in  1  weights loaded, level
- lst_rdy  in  1  upstream act valid, level
- lst_get  out  1  act consumed, pulse
- flg_act_i  in  CH  sparsity flags in
- act_i  in  DW*CH  activations in
- nxt_rdy  out  1  act held for downstream, level
- nxt_get  in  1  downstream consumed, pulse
- flg_act_o  out  CH  latched flags to MACs
- act_o  out  DW*CH  latched activations to MACs
- mac_sta  out  1  MAC start pulse
- mac_fnh  in  KH*KW  per-MAC finish pulses
- pls_acc  out  1  all MACs finished, pulse
- ram_en_rd, ram_en_wr  out  1  psum SRAM enables
- ram_addr_rd, ram_addr_wr  out  AW  psum SRAM addresses
- err_ovf  out  1  sticky address overflow

Function
REQ-003 FSM states SHALL be IDLE, CFGWEI, WAITACT, HOLD; IDLE->CFGWEI unconditionally next cycle.
REQ-004 CFGWEI SHALL go to WAITACT when wei_rdy=1.
REQ-005 In WAITACT, when lst_rdy=1 and done mask full, SHALL pulse lst_get for 1 cycle, latch flg_act_i/act_i to outputs on that edge, go to HOLD.
REQ-006 mac_sta SHALL pulse exactly 1 cycle after lst_get if latched flags non-zero; if all zero (zero-skip), mac_sta SHALL stay 0 and done mask SHALL be set full on the same edge.
REQ-007 Done mask (KH*KW bits, sticky) SHALL set bits on mac_fnh and clear all on mac_sta; full at reset exit so first act is accepted.
REQ-008 pls_acc SHALL pulse 1 cycle on the cycle the mask turns full (0->full transition only, includes zero-skip case).
REQ-009 nxt_rdy SHALL be 1 exactly while state=HOLD; HOLD->WAITACT on nxt_get=1 (LAST=1: HOLD lasts 1 cycle).
REQ-010 fnh_blk in any state except IDLE SHALL force IDLE next cycle, reset both RAM addresses, set done mask full; fnh_blk has priority over all other events.
REQ-011 ram_en_rd SHALL equal sta_row; ram_addr_rd SHALL increment after each sta_row, wrapping to 0 at cfg_len-1.
REQ-012 ram_en_wr SHALL equal fnh_row; ram_addr_wr SHALL likewise increment and wrap at cfg_len-1.
REQ-013 err_ovf SHALL set when sta_row occurs with write address more than 1 row behind read address modulo cfg_len, or fnh_row with write address equal to read address; cleared only by reset.
REQ-014 Simultaneous sta_row and fnh_row SHALL advance both addresses independently.
REQ-015 cfg_len SHALL be sampled only in IDLE; changes elsewhere ignored.

Reset
REQ-016 On rst_n low: state IDLE; all pulses, nxt_rdy, err_ovf, flg_act_o, act_o, addresses 0; done mask full.
REQ-017 Reset mid-operation SHALL abandon held act without lst_get/nxt_get side effects.

Structure
REQ-018 Shared package SHALL hold FSM state enum, DW/CH/LEN_PSUM defaults, and the address-wrap increment function.
REQ-019 One sub-module pec_psum_addr (address counter with wrap, enable, clear) SHALL be instantiated twice, read and write.

Verification
REQ-020 Reset release, wei_rdy=1 at cycle 3, lst_rdy=1 -> lst_get at cycle 5, mac_sta at 6, nxt_rdy=1 from 6.
REQ-021 flg_act_i=0 -> no mac_sta, pls_acc 1 cycle after lst_get, next act accepted without mac_fnh.
REQ-022 mac_fnh bits arrive staggered over 9 cycles (KH=KW=3) -> single pls_acc on the cycle after last bit.
REQ-023 cfg_len=5, 7 sta_row/fnh_row pairs -> addresses 0,1,2,3,4,0,1; err_ovf stays 0.
REQ-024 fnh_blk asserted in HOLD with nxt_get simultaneous -> IDLE next, addresses 0, no further nxt_rdy.
REQ-025 Two fnh_row without sta_row from reset -> err_ovf=1 after second.
